// File: rtl/uart_loader_pkg.sv
// loader_pkg: shared widths, protocol bytes and FSM state codes for uart_loader.
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned ST_W   = 4;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] ACK       = 8'h06;
  localparam logic [BYTE_W-1:0] NAK       = 8'h15;

  // Receive states occupy the contiguous range ST_CMD..ST_CSUM (timer window).
  localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
  localparam logic [ST_W-1:0] ST_CMD    = 4'd1;
  localparam logic [ST_W-1:0] ST_ADDR_L = 4'd2;
  localparam logic [ST_W-1:0] ST_ADDR_H = 4'd3;
  localparam logic [ST_W-1:0] ST_LEN_L  = 4'd4;
  localparam logic [ST_W-1:0] ST_LEN_H  = 4'd5;
  localparam logic [ST_W-1:0] ST_DATA_L = 4'd6;
  localparam logic [ST_W-1:0] ST_DATA_H = 4'd7;
  localparam logic [ST_W-1:0] ST_CSUM   = 4'd8;
  localparam logic [ST_W-1:0] ST_REPLY  = 4'd9;
  localparam logic [ST_W-1:0] ST_RD_REQ = 4'd10;
  localparam logic [ST_W-1:0] ST_RD_WAIT = 4'd11;
  localparam logic [ST_W-1:0] ST_RD_TXL = 4'd12;
  localparam logic [ST_W-1:0] ST_RD_TXH = 4'd13;

  // Saturating increment for the error counter.
  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
    return (v == '1) ? v : v + BYTE_W'(1);
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: UART byte stream, memory write/read port and stall/status lines.
interface uart_loader_if;
  import loader_pkg::*;

  logic [BYTE_W-1:0] rxData;
  logic              rxReady;
  logic [BYTE_W-1:0] txData;
  logic              txStart;
  logic              txBusy;
  logic [ADDR_W-1:0] memAddr;
  logic [WORD_W-1:0] memWdata;
  logic              memWrite;
  logic              memRead;
  logic [WORD_W-1:0] memRdata;
  logic              hold;
  logic [BYTE_W-1:0] errCount;

  modport master (
    input  rxData, rxReady, txBusy, memRdata,
    output txData, txStart, memAddr, memWdata, memWrite, memRead, hold, errCount
  );

  modport slave (
    output rxData, rxReady, txBusy, memRdata,
    input  txData, txStart, memAddr, memWdata, memWrite, memRead, hold, errCount
  );

endinterface

// File: rtl/uart_loader_timeout.sv
// loader_timeout: inter-byte idle timer; expire_c fires in the cycle the count reaches LIMIT.
module loader_timeout #(
  parameter int unsigned LIMIT = 1_200_000,
  parameter int unsigned W     = 21
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [W-1:0] cnt;

  // Count idle cycles while enabled; a clear always wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign expire_c = en && !clr && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/uart_loader.sv
// uart_loader: framed UART command parser writing 16-bit words to memory while stalling the core.
// Optional readback (CMD 0x52) is built when LOADER_READBACK_EN is defined.
module uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000,
  parameter int unsigned TIMER_W        = 21
) (
  input  logic          CLK,
  input  logic          RST_N,
  uart_loader_if.master bus
);

  logic [ST_W-1:0]   state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [WORD_W-1:0] wdata, wdata_d;
  logic [WORD_W-1:0] remain, remain_d;
  logic [BYTE_W-1:0] txd, txd_d, err, err_d, sum, sum_d, lo, lo_d;
  logic              wr, wr_d, txs, txs_d, hold, hold_d, ok, ok_d;
  logic              tx_ok, tmr_en, tmr_clr, expire_c;
`ifdef LOADER_READBACK_EN
  logic              rd, rd_d, is_read, is_read_d;
  logic [WORD_W-1:0] rdbuf, rdbuf_d;
`else
  logic              unused_rdata;
  assign unused_rdata = ^bus.memRdata;
`endif

  // Inter-byte timer runs only in receive states and restarts on every byte.
  assign tmr_en  = (state >= ST_CMD) && (state <= ST_CSUM);
  assign tmr_clr = bus.rxReady || (state == ST_IDLE);

  loader_timeout #(.LIMIT(TIMEOUT_CYCLES), .W(TIMER_W)) u_timeout (
    .CLK(CLK), .RST_N(RST_N), .clr(tmr_clr), .en(tmr_en), .expire_c(expire_c)
  );

  // The UART busy flag lags txStart by a cycle, so never launch back-to-back.
  assign tx_ok = !bus.txBusy && !txs;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state; addr_d = addr; wdata_d = wdata; remain_d = remain;
    txd_d = txd; err_d = err; sum_d = sum; lo_d = lo; hold_d = hold; ok_d = ok;
    wr_d = 1'b0; txs_d = 1'b0;
`ifdef LOADER_READBACK_EN
    rd_d = 1'b0; is_read_d = is_read; rdbuf_d = rdbuf;
`endif
    if (wr) addr_d = addr + ADDR_W'(1);
    case (state)
      ST_IDLE: begin
        hold_d = 1'b0;
        if (bus.rxReady && bus.rxData == SYNC_BYTE) begin
          state_d = ST_CMD; hold_d = 1'b1; sum_d = '0;
        end
      end
      ST_CMD: if (bus.rxReady) begin
        sum_d = sum + bus.rxData;
        if (bus.rxData == CMD_WRITE) begin
          state_d = ST_ADDR_L;
`ifdef LOADER_READBACK_EN
          is_read_d = 1'b0;
        end else if (bus.rxData == CMD_READ) begin
          state_d = ST_ADDR_L;
          is_read_d = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE; hold_d = 1'b0; err_d = sat_inc(err);
        end
      end
      ST_ADDR_L: if (bus.rxReady) begin
        sum_d = sum + bus.rxData; addr_d = {addr[15:8], bus.rxData}; state_d = ST_ADDR_H;
      end
      ST_ADDR_H: if (bus.rxReady) begin
        sum_d = sum + bus.rxData; addr_d = {bus.rxData, addr[7:0]}; state_d = ST_LEN_L;
      end
      ST_LEN_L: if (bus.rxReady) begin
        sum_d = sum + bus.rxData; remain_d = {remain[15:8], bus.rxData}; state_d = ST_LEN_H;
      end
      ST_LEN_H: if (bus.rxReady) begin
        sum_d = sum + bus.rxData;
        remain_d = {bus.rxData, remain[7:0]};
        if ({bus.rxData, remain[7:0]} == '0) state_d = ST_CSUM;
`ifdef LOADER_READBACK_EN
        else if (is_read) state_d = ST_CSUM;
`endif
        else state_d = ST_DATA_L;
      end
      ST_DATA_L: if (bus.rxReady) begin
        sum_d = sum + bus.rxData; lo_d = bus.rxData; state_d = ST_DATA_H;
      end
      // Words commit immediately; a later checksum failure does not undo them.
      ST_DATA_H: if (bus.rxReady) begin
        sum_d = sum + bus.rxData;
        wdata_d = {bus.rxData, lo};
        wr_d = 1'b1;
        remain_d = remain - WORD_W'(1);
        state_d = (remain == WORD_W'(1)) ? ST_CSUM : ST_DATA_L;
      end
      ST_CSUM: if (bus.rxReady) begin
        ok_d = (bus.rxData == sum);
        if (bus.rxData != sum) err_d = sat_inc(err);
        state_d = ST_REPLY;
      end
      ST_REPLY: if (tx_ok) begin
        txs_d = 1'b1; txd_d = ok ? ACK : NAK; state_d = ST_IDLE;
`ifdef LOADER_READBACK_EN
        if (ok && is_read && remain != '0) begin
          state_d = ST_RD_REQ; rd_d = 1'b1;
        end
`endif
      end
`ifdef LOADER_READBACK_EN
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        rdbuf_d = bus.memRdata; state_d = ST_RD_TXL;
      end
      ST_RD_TXL: if (tx_ok) begin
        txs_d = 1'b1; txd_d = rdbuf[7:0]; state_d = ST_RD_TXH;
      end
      ST_RD_TXH: if (tx_ok) begin
        txs_d = 1'b1; txd_d = rdbuf[15:8];
        addr_d = addr + ADDR_W'(1);
        remain_d = remain - WORD_W'(1);
        if (remain == WORD_W'(1)) state_d = ST_IDLE;
        else begin
          state_d = ST_RD_REQ; rd_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE; hold_d = 1'b0;
      end
    endcase
    if (expire_c) begin
      state_d = ST_IDLE; hold_d = 1'b0; err_d = sat_inc(err);
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE; addr <= '0; wdata <= '0; remain <= '0;
      txd <= '0; err <= '0; sum <= '0; lo <= '0;
      wr <= 1'b0; txs <= 1'b0; hold <= 1'b0; ok <= 1'b0;
`ifdef LOADER_READBACK_EN
      rd <= 1'b0; is_read <= 1'b0; rdbuf <= '0;
`endif
    end else begin
      state <= state_d; addr <= addr_d; wdata <= wdata_d; remain <= remain_d;
      txd <= txd_d; err <= err_d; sum <= sum_d; lo <= lo_d;
      wr <= wr_d; txs <= txs_d; hold <= hold_d; ok <= ok_d;
`ifdef LOADER_READBACK_EN
      rd <= rd_d; is_read <= is_read_d; rdbuf <= rdbuf_d;
`endif
    end
  end

  assign bus.memAddr  = addr;
  assign bus.memWdata = wdata;
  assign bus.memWrite = wr;
  assign bus.txData   = txd;
  assign bus.txStart  = txs;
  assign bus.hold     = hold;
  assign bus.errCount = err;
`ifdef LOADER_READBACK_EN
  assign bus.memRead  = rd;
`else
  assign bus.memRead  = 1'b0;
`endif

endmodule
